// File: rtl/dm_lsu.sv
// Load/store unit in front of a word-wide data memory: byte/half/word loads with extension,
// sub-word stores via read-modify-write, and rejection of misaligned or out-of-range accesses.
module dm_lsu #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StMerge  = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              is_store;
    logic              is_uns;
    logic [1:0]        size;
    logic [4:0]        lane_sh;
    logic [31:0]       lane_word;
    logic [31:0]       load_ext;
    logic [31:0]       lane_mask;
    logic [31:0]       merged;
    logic [31:0]       hi_bits;
    logic              req_bad;

    assign is_store = op_q[3];
    assign is_uns   = op_q[2];
    assign size     = op_q[1:0];
    assign lane_sh  = {addr_q[1:0], 3'b000};

    // Request validation happens on the raw inputs, at the acceptance edge.
    always_comb begin
        hi_bits = req_addr >> ADDR_W;
        unique case (req_op[1:0])
            SzByte:  req_bad = 1'b0;
            SzHalf:  req_bad = req_addr[0];
            SzWord:  req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
        req_bad = req_bad | (|hi_bits);
    end

    // Shift the addressed lane down to bit 0, then extend from its MSB.
    always_comb begin
        lane_word = dm_dout >> lane_sh;
        unique case (size)
            SzByte:  load_ext = {{24{~is_uns & lane_word[7]}}, lane_word[7:0]};
            SzHalf:  load_ext = {{16{~is_uns & lane_word[15]}}, lane_word[15:0]};
            default: load_ext = dm_dout;
        endcase
    end

    always_comb begin
        if (size == SzByte) begin
            lane_mask = 32'h0000_00ff << lane_sh;
        end else begin
            lane_mask = 32'h0000_ffff << lane_sh;
        end
        merged = (word_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr[ADDR_W-1:0];
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (!is_store) begin
                    rdata_d = load_ext;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (size == SzWord) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    word_d  = dm_dout;
                    state_d = StMerge;
                end
            end
            StMerge: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_data  = rdata_q;
    assign resp_err   = err_q;

    // Gated by rst directly so a reset landing mid-operation can never commit a write.
    assign dm_we   = rst & (((state_q == StAccess) & is_store & (size == SzWord)) |
                            (state_q == StMerge));
    assign dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign dm_din  = (state_q == StMerge) ? merged : wdata_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: behavioural dm_1k, byte-lane reference memory and a response scoreboard.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    always #5 clk = ~clk;

    dm_lsu #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_dout   (dm_dout)
    );

    // dm_1k stand-in: synchronous write, combinational read.
    logic [31:0] mem [256];
    always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_din;
    assign dm_dout = mem[dm_addr[9:2]];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          acc_q[$];
    logic [31:0] ref_mem [256];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          resp_cnt = 0;
    int          rdy_viol = 0;
    bit          busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Reference model works on a byte array so lane selection is independent of the RTL's shifts.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] wd);
        exp_t       e;
        logic [7:0] b [4];
        logic [31:0] w;
        int         off;
        logic [1:0] sz;
        logic       bad;
        sz  = op[1:0];
        off = int'(a[1:0]);
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
              (a[31:10] != 22'd0);
        e.data = 32'd0;
        e.err  = bad;
        e.lat  = 1;
        if (bad) return e;
        w = ref_mem[a[9:2]];
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        if (op[3]) begin
            if (sz == 2'b00) begin
                b[off] = wd[7:0];
                e.lat  = 3;
            end else if (sz == 2'b01) begin
                b[off]     = wd[7:0];
                b[off + 1] = wd[15:8];
                e.lat      = 3;
            end else begin
                for (int k = 0; k < 4; k++) b[k] = wd[8*k +: 8];
                e.lat = 2;
            end
            ref_mem[a[9:2]] = {b[3], b[2], b[1], b[0]};
        end else begin
            e.lat = 2;
            if (sz == 2'b00) begin
                e.data = op[2] ? {24'd0, b[off]} : {{24{b[off][7]}}, b[off]};
            end else if (sz == 2'b01) begin
                e.data = op[2] ? {16'd0, b[off + 1], b[off]} :
                                 {{16{b[off + 1][7]}}, b[off + 1], b[off]};
            end else begin
                e.data = w;
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            acc_q.delete();
            busy = 1'b0;
        end else if (req_valid && req_ready) begin
            acc_q.push_back(cyc);
            busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (dm_we) we_cnt++;
        if (busy && req_ready) rdy_viol++;
        if (resp_valid) begin
            resp_cnt++;
            busy = 1'b0;
            if (sb_q.size() == 0 || acc_q.size() == 0) begin
                check("spurious_resp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                a = acc_q.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check("latency", cyc - a + 1, e.lat);
            end
        end
    end

    // Presents a request and returns at the negedge after its acceptance edge; valid stays high.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        int n;
        sb_q.push_back(model(op, a, wd));
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        req_valid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("drain_timeout", sb_q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          w0;
        int          r0;
        logic [31:0] p;
        logic [31:0] saved;
        logic [31:0] pw [10];

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        rst = 1'b0;
        req_valid = 1'b0;
        req_op = 4'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        // Word round-trip
        w0 = we_cnt;
        send(4'b1010, 32'h010, 32'h1122_3344);
        drain();
        send(4'b0010, 32'h010, 32'hdead_beef);
        drain();
        check("rt_we_pulses", we_cnt - w0, 32'd1);
        check("rt_mem", mem[4], 32'h1122_3344);

        // Byte merge and extension
        send(4'b1010, 32'h020, 32'haabb_ccdd);
        send(4'b1000, 32'h021, 32'hffff_ff80);
        drain();
        check("sb_merge_mem", mem[8], 32'haabb_80dd);
        send(4'b0000, 32'h021, 32'd0);
        send(4'b0100, 32'h021, 32'd0);
        send(4'b0000, 32'h023, 32'd0);
        send(4'b0100, 32'h020, 32'd0);
        drain();

        // Half lanes
        send(4'b1010, 32'h030, 32'h0000_0000);
        send(4'b1001, 32'h032, 32'h1234_8001);
        drain();
        check("sh_merge_mem", mem[12], 32'h8001_0000);
        send(4'b0001, 32'h032, 32'd0);
        send(4'b0101, 32'h032, 32'd0);
        send(4'b0101, 32'h030, 32'd0);
        drain();

        // Errors: none may touch memory
        w0 = we_cnt;
        send(4'b0001, 32'h001, 32'd0);
        send(4'b0010, 32'h002, 32'd0);
        send(4'b1010, 32'h400, 32'h0bad_0bad);
        send(4'b0011, 32'h010, 32'd0);
        send(4'b1011, 32'h010, 32'h0000_dead);
        send(4'b1000, 32'h8000_0010, 32'h0000_0055);
        drain();
        check("err_we_pulses", we_cnt - w0, 32'd0);
        check("err_mem_intact", mem[4], 32'h1122_3344);
        check("err_mem0_intact", mem[0], ref_mem[0]);

        // Reset landing in MERGE of a byte store
        send(4'b1010, 32'h040, 32'h5566_7788);
        drain();
        saved = ref_mem[16];
        r0 = resp_cnt;
        send(4'b1000, 32'h041, 32'h0000_0011);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("we_in_rst", {31'd0, dm_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        ref_mem[16] = saved;
        repeat (3) @(negedge clk);
        check("rst_no_resp", resp_cnt - r0, 32'd0);
        check("rst_ready_after", {31'd0, req_ready}, 32'd1);
        check("rst_data_cleared", resp_data, 32'd0);
        check("rst_mem_intact", mem[16], 32'h5566_7788);

        // Back-to-back with req_valid held high
        p = 32'd1;
        for (int i = 0; i < 10; i++) begin
            pw[i] = p;
            send(4'b1010, i * 4, p);
            p = p * 32'd9;
        end
        for (int i = 9; i >= 0; i--) send(4'b0010, i * 4, 32'hffff_ffff);
        drain();
        for (int i = 0; i < 10; i++) check("b2b_mem", mem[i], pw[i]);
        check("b2b_last", pw[9], 32'd387420489);
        check("ready_while_busy", rdy_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
